// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// IF/ID instruction-mux select codes and the canonical NOP instruction word.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2,
      ST_WAIT  = 2'd3
   } state_e;

   localparam logic [1:0]  SEL_LIVE   = 2'b00;
   localparam logic [1:0]  SEL_REPLAY = 2'b01;
   localparam logic [1:0]  SEL_NOP    = 2'b10;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

endpackage : pipe_pkg

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counters for the pipeline controller: stall entries,
// flush entries and memory-wait cycles. Each counter sticks at all-ones.
module pipe_perf_cnt #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             stall_evt_i,
   input  logic             flush_evt_i,
   input  logic             wait_evt_i,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic [CNT_W-1:0] wait_cnt_o
);

   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [CNT_W-1:0] wait_q,  wait_d;

   // Next-count logic: increment on event unless already saturated
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      wait_d  = wait_q;
      if (stall_evt_i && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
      if (flush_evt_i && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
      if (wait_evt_i  && (wait_q  != '1)) wait_d  = wait_q  + CNT_W'(1);
   end

   // Counter registers, cleared asynchronously by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
         flush_q <= '0;
         wait_q  <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
         wait_q  <= wait_d;
      end
   end

   assign stall_cnt_o = stall_q;
   assign flush_cnt_o = flush_q;
   assign wait_cnt_o  = wait_q;

endmodule : pipe_perf_cnt

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and memory-wait
// freeze for a classic 5-stage pipeline.
// Optional feature macro: PIPE_CTRL_PERF_EN adds saturating performance
// counters (stall_cnt, flush_cnt, wait_cnt).
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             branch_taken,
   input  logic             mem_wait,
   output logic             pc_write,
   output logic             if_id_write,
   output logic [1:0]       instr_sel,
   output logic             id_ex_flush,
   output logic             pipe_hold
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
`endif
);

   if (CNT_W == 0) begin : g_bad_cnt_w
      $error("pipe_ctrl: CNT_W must be at least 1");
   end

   state_e state_q, state_d;
   logic   branch_pending_q, branch_pending_d;
   logic   load_use;

   // Load in EX feeding a source the ID instruction actually reads; x0 never hazards
   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) ||
                  (id_rs2_used && (id_rs2 == ex_rd)));
   end

   // State and pending-branch registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= ST_RUN;
         branch_pending_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         branch_pending_q <= branch_pending_d;
      end
   end

   // Next-state: mem_wait dominates, then branch, then load-use
   always_comb begin
      state_d          = state_q;
      branch_pending_d = branch_pending_q;
      if (mem_wait) begin
         state_d = ST_WAIT;
         if (branch_taken) branch_pending_d = 1'b1;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (branch_taken)  state_d = ST_FLUSH;
               else if (load_use) state_d = ST_STALL;
               else               state_d = ST_RUN;
            end
            ST_STALL: state_d = branch_taken ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            ST_WAIT: begin
               // A redirect that arrived while frozen is honoured on release
               branch_pending_d = 1'b0;
               state_d = (branch_pending_q || branch_taken) ? ST_FLUSH : ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Outputs: forced to run values while reset is asserted
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      instr_sel   = SEL_LIVE;
      id_ex_flush = 1'b0;
      pipe_hold   = 1'b0;
      if (rst) begin
         if (mem_wait) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            instr_sel   = SEL_REPLAY;
            pipe_hold   = 1'b1;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (branch_taken) begin
                     id_ex_flush = 1'b1;
                  end else if (load_use) begin
                     pc_write    = 1'b0;
                     if_id_write = 1'b0;
                     id_ex_flush = 1'b1;
                  end
               end
               ST_STALL: begin
                  instr_sel   = SEL_REPLAY;
                  id_ex_flush = branch_taken;
               end
               ST_FLUSH: instr_sel = SEL_NOP;
               ST_WAIT: begin
                  instr_sel   = SEL_REPLAY;
                  id_ex_flush = branch_pending_q || branch_taken;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   logic stall_evt, flush_evt, wait_evt;

   // Event pulses for the counters: state entries and cycles spent waiting
   always_comb begin
      stall_evt = (state_d == ST_STALL) && (state_q != ST_STALL);
      flush_evt = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
      wait_evt  = (state_q == ST_WAIT);
   end

   pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk_i       (clk),
      .rst_ni      (rst),
      .stall_evt_i (stall_evt),
      .flush_evt_i (flush_evt),
      .wait_evt_i  (wait_evt),
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt),
      .wait_cnt_o  (wait_cnt)
   );
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. Output vector packing:
// {pc_write, if_id_write, instr_sel[1:0], id_ex_flush, pipe_hold}.
module tb_pipe_ctrl;

   localparam logic [5:0] O_RUN   = 6'b110000;
   localparam logic [5:0] O_LU    = 6'b000010;
   localparam logic [5:0] O_STALL = 6'b110100;
   localparam logic [5:0] O_BR    = 6'b110010;
   localparam logic [5:0] O_STBR  = 6'b110110;
   localparam logic [5:0] O_FLUSH = 6'b111000;
   localparam logic [5:0] O_WAIT  = 6'b000101;
   localparam logic [5:0] O_RELBR = 6'b110110;
   localparam logic [5:0] O_REL   = 6'b110100;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_rs1_used, id_rs2_used, ex_mem_read, branch_taken, mem_wait;
   logic       pc_write, if_id_write, id_ex_flush, pipe_hold;
   logic [1:0] instr_sel;
   logic [5:0] outs;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt, flush_cnt, wait_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign outs = {pc_write, if_id_write, instr_sel, id_ex_flush, pipe_hold};

   pipe_ctrl #(.REG_W(5), .CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .branch_taken (branch_taken),
      .mem_wait     (mem_wait),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .instr_sel    (instr_sel),
      .id_ex_flush  (id_ex_flush),
      .pipe_hold    (pipe_hold)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .wait_cnt     (wait_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic mw);
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rs1_used  = u1;
      id_rs2_used  = u2;
      ex_rd        = rd;
      ex_mem_read  = mr;
      branch_taken = br;
      mem_wait     = mw;
   endtask

   // Apply inputs after the falling edge, check mid-cycle before the next rise
   task automatic step(input string tag, input logic [5:0] exp,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic mw);
      @(negedge clk);
      drive(rs1, rs2, u1, u2, rd, mr, br, mw);
      #1 chk(tag, {26'd0, outs}, {26'd0, exp});
   endtask

   initial begin
      rst = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #2 chk("reset_outs", {26'd0, outs}, {26'd0, O_RUN});
`ifdef PIPE_CTRL_PERF_EN
      chk("reset_stall_cnt", stall_cnt, 32'd0);
      chk("reset_flush_cnt", flush_cnt, 32'd0);
      chk("reset_wait_cnt",  wait_cnt,  32'd0);
`endif
      // mem_wait during reset must not leak to the outputs
      mem_wait = 1'b1;
      #1 chk("reset_masks_wait", {26'd0, outs}, {26'd0, O_RUN});
      mem_wait = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      step("idle",        O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      // load-use on rs1; STALL ignores a still-present hazard
      step("lu_rs1_c0",   O_LU,    5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      step("lu_rs1_c1",   O_STALL, 5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
      step("lu_rs1_c2",   O_RUN,   5'd5, 5'd1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);

      // load-use on rs2
      step("lu_rs2_c0",   O_LU,    5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      step("lu_rs2_c1",   O_STALL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("lu_rs2_c2",   O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      // no hazard: source not used, not a load, destination x0
      step("rs1_unused",  O_RUN,   5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      step("not_load",    O_RUN,   5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      step("x0_no_stall", O_RUN,   5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);

      // branch flush
      step("br_c0",       O_BR,    5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("br_c1",       O_FLUSH, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("br_c2",       O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      // branch beats load-use; FLUSH ignores load-use
      step("br_lu_c0",    O_BR,    5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
      step("br_lu_c1",    O_FLUSH, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
      step("br_lu_c2",    O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      // branch resolved while in STALL
      step("st_br_c0",    O_LU,    5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
      step("st_br_c1",    O_STBR,  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      step("st_br_c2",    O_FLUSH, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("st_br_c3",    O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      // branch colliding with a 3-cycle memory wait
      for (int i = 0; i < 3; i++)
         step($sformatf("coll_wait%0d", i), O_WAIT,
              5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      step("coll_release", O_RELBR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("coll_flush",   O_FLUSH, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("coll_run",     O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

      // plain wait (mem_wait beats load-use); pending must be clear on release
      step("wait_lu",      O_WAIT,  5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1);
      step("wait_c1",      O_WAIT,  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      step("wait_release", O_REL,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("wait_run",     O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
      chk("stall_cnt", stall_cnt, 32'd3);
      chk("flush_cnt", flush_cnt, 32'd4);
      chk("wait_cnt",  wait_cnt,  32'd5);
`endif

      // reset pulsed mid-WAIT with a branch pending
      step("rw_coll",      O_WAIT,  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      step("rw_wait",      O_WAIT,  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      #1 chk("rw_async_outs", {26'd0, outs}, {26'd0, O_RUN});
`ifdef PIPE_CTRL_PERF_EN
      chk("rw_stall_cnt", stall_cnt, 32'd0);
      chk("rw_flush_cnt", flush_cnt, 32'd0);
      chk("rw_wait_cnt",  wait_cnt,  32'd0);
`endif
      mem_wait = 1'b0;
      #1 rst = 1'b1;
      step("rw_run",       O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("rw_wait2",     O_WAIT,  5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      step("rw_pend_clr",  O_REL,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      step("rw_run2",      O_RUN,   5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
      chk("end_stall_cnt", stall_cnt, 32'd0);
      chk("end_flush_cnt", flush_cnt, 32'd0);
      chk("end_wait_cnt",  wait_cnt,  32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register-index width.
REQ-002 SHALL have parameter CNT_W, default 32, meaning performance-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_rs1, id_rs2  input  REG_W each  source registers of the instruction in ID.
REQ-006 SHALL have port id_rs1_used, id_rs2_used  input  1 each  source actually read.
REQ-007 SHALL have port ex_rd  input  REG_W  destination of the instruction in EX.
REQ-008 SHALL have port ex_mem_read  input  1  EX instruction is a load.
REQ-009 SHALL have port branch_taken  input  1  EX resolved a redirect (taken branch/jump).
REQ-010 SHALL have port mem_wait  input  1  instruction or data memory not ready.
REQ-011 SHALL have port pc_write  output  1  PC update enable.
REQ-012 SHALL have port if_id_write  output  1  IF/ID pc capture enable.
REQ-013 SHALL have port instr_sel  output  2  IF/ID instruction mux: 00 live, 01 replay held, 10 NOP (32'h0000_0013).
REQ-014 SHALL have port id_ex_flush  output  1  load bubble into ID/EX.
REQ-015 SHALL have port pipe_hold  output  1  freeze ID/EX, EX/MEM, MEM/WB.

Function
REQ-016 SHALL implement FSM states RUN, STALL, FLUSH, WAIT.
REQ-017 SHALL define load_use = ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-018 SHALL resolve priority as mem_wait > branch_taken > load_use within any cycle.
REQ-019 SHALL in RUN with no event drive pc_write=1, if_id_write=1, instr_sel=00, id_ex_flush=0, pipe_hold=0.
REQ-020 SHALL in RUN with load_use drive pc_write=0, if_id_write=0, id_ex_flush=1, instr_sel=00; next state STALL.
REQ-021 SHALL in STALL drive instr_sel=01, pc_write=1, if_id_write=1; next state RUN; exactly one stall cycle per load-use.
REQ-022 SHALL in RUN or STALL with branch_taken drive id_ex_flush=1, pc_write=1; next state FLUSH.
REQ-023 SHALL in FLUSH drive instr_sel=10, pc_write=1, if_id_write=1, ignore load_use; next state RUN.
REQ-024 SHALL on mem_wait in any state drive pc_write=0, if_id_write=0, pipe_hold=1, id_ex_flush=0; next state WAIT.
REQ-025 SHALL in WAIT drive instr_sel=01 with the same hold outputs while mem_wait=1.
REQ-026 SHALL latch branch_pending when branch_taken and mem_wait coincide; on mem_wait release, go FLUSH if branch_pending else RUN, clearing it.
REQ-027 SHALL treat ex_rd==0 as no hazard.

Reset
REQ-028 SHALL on rst low force state RUN, branch_pending=0, pc_write=1, if_id_write=1, instr_sel=00, id_ex_flush=0, pipe_hold=0, counters 0, regardless of clk.
REQ-029 SHALL begin normal evaluation on the first rising clk after rst deasserts.

Configuration
REQ-030 SHALL under PIPE_CTRL_PERF_EN add outputs stall_cnt, flush_cnt, wait_cnt (CNT_W each), counting STALL entries, FLUSH entries and WAIT cycles, saturating at all-ones.
REQ-031 SHALL without PIPE_CTRL_PERF_EN omit those ports and counters; control behaviour identical.

Structure
REQ-032 SHALL place the state enum and the instr_sel encodings (SEL_LIVE, SEL_REPLAY, SEL_NOP) and the NOP constant in shared package pipe_pkg.
REQ-033 SHALL implement the counters in sub-module pipe_perf_cnt, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-034 SHALL cover load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 used -> cycle0 pc_write=0, id_ex_flush=1; cycle1 instr_sel=01; cycle2 RUN outputs.
REQ-035 SHALL cover x0: ex_mem_read=1, ex_rd=0, id_rs1=0 used -> no stall, pc_write=1.
REQ-036 SHALL cover branch: branch_taken=1 -> id_ex_flush=1 same cycle; next cycle instr_sel=10; then 00.
REQ-037 SHALL cover collision: branch_taken=1 and mem_wait=1 for 3 cycles -> pipe_hold=1, instr_sel=01 for 3 cycles, then FLUSH with instr_sel=10.
REQ-038 SHALL cover rst pulsed low mid-WAIT -> outputs return to reset values immediately, branch_pending cleared, with PIPE_CTRL_PERF_EN counters read 0.
